// File: rtl/tree_walk_classifier.sv
// rtl/tree_walk_classifier.sv - decision-tree packet classifier walking LEAF/CUT/PARTITION nodes from external node memory
package tree_walk_classifier_pkg;
  localparam int MAX_FANOUT = 4;
  localparam logic [1:0] NODE_LEAF      = 2'd0;
  localparam logic [1:0] NODE_CUT       = 2'd1;
  localparam logic [1:0] NODE_PARTITION = 2'd2;

  typedef struct packed {
    logic [15:0] key;
  } packet_s;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [7:0]  weight;
    logic [7:0]  id;
  } rule_s;

  // lo/hi is the node's own key range, probed when it is a CUT child.
  typedef struct packed {
    logic [1:0]                  node_type;
    logic [2:0]                  count;
    logic [15:0]                 lo;
    logic [15:0]                 hi;
    logic [MAX_FANOUT-1:0][15:0] children;
    rule_s [MAX_FANOUT-1:0]      rules;
  } node_s;

  function automatic logic rule_match(input packet_s p, input rule_s r);
    return (p.key >= r.lo) && (p.key <= r.hi);
  endfunction

  function automatic logic [2:0] fanout(input logic [2:0] c);
    return (c > 3'd4) ? 3'd4 : c;
  endfunction
endpackage

module tree_walk_classifier
  import tree_walk_classifier_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 16,
  parameter int MAX_STEPS   = 1024,
  parameter int TAG_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  packet_s           in_packet,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  node_s             mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_found,
  output rule_s             out_rule,
  output logic              out_error
);
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, CUT_FETCH, CUT_CHECK, PUSH, POP, DONE} state_e;
  state_e state, state_next;

  logic [ADDR_W-1:0]           cur_addr;
  logic [ADDR_W-1:0]           stack [STACK_DEPTH];
  logic [SP_W-1:0]             sp, top;
  logic [STEP_W-1:0]           steps;
  logic [MAX_FANOUT-1:0][15:0] kids;
  logic [2:0]                  kid_count, rd_count, idx;
  packet_s                     packet;
  logic [7:0]                  best_w;
  logic                        step_limit, stack_full, child_hit, leaf_hit;
  rule_s                       leaf_rule;

  assign rd_count   = fanout(mem_rdata.count);
  assign step_limit = (steps == STEP_W'(MAX_STEPS));
  assign stack_full = (sp == SP_W'(STACK_DEPTH));
  assign top        = sp - SP_W'(1);
  assign child_hit  = (packet.key >= mem_rdata.lo) && (packet.key <= mem_rdata.hi);

  // Lowest weight wins; strict compare keeps the lowest index on ties.
  always_comb begin
    leaf_hit  = 1'b0;
    leaf_rule = '0;
    for (int i = 0; i < MAX_FANOUT; i++) begin
      if (3'(i) < rd_count && rule_match(packet, mem_rdata.rules[i]) &&
          (!leaf_hit || mem_rdata.rules[i].weight < leaf_rule.weight)) begin
        leaf_hit  = 1'b1;
        leaf_rule = mem_rdata.rules[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = cur_addr;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = FETCH;
      end
      FETCH: begin
        mem_req    = !step_limit;
        state_next = step_limit ? DONE : DECODE;
      end
      DECODE: begin
        case (mem_rdata.node_type)
          NODE_LEAF:      state_next = POP;
          NODE_CUT:       state_next = (rd_count == 3'd0) ? POP : CUT_FETCH;
          NODE_PARTITION: state_next = (rd_count == 3'd0) ? POP : PUSH;
          default:        state_next = DONE;
        endcase
      end
      CUT_FETCH: begin
        mem_req    = 1'b1;
        mem_addr   = ADDR_W'(kids[idx[1:0]]);
        state_next = CUT_CHECK;
      end
      CUT_CHECK: begin
        if (child_hit)                      state_next = FETCH;
        else if ((idx + 3'd1) < kid_count)  state_next = CUT_FETCH;
        else                                state_next = POP;
      end
      PUSH: begin
        if (stack_full)        state_next = DONE;
        else if (idx == 3'd0)  state_next = POP;
      end
      POP: state_next = (sp == '0) ? DONE : FETCH;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr  <= '0;
      sp        <= '0;
      steps     <= '0;
      kids      <= '0;
      kid_count <= '0;
      idx       <= '0;
      packet    <= '0;
      best_w    <= '1;
      out_tag   <= '0;
      out_found <= 1'b0;
      out_error <= 1'b0;
      out_rule  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          packet    <= in_packet;
          out_tag   <= in_tag;
          best_w    <= '1;
          out_found <= 1'b0;
          out_error <= 1'b0;
          out_rule  <= '0;
          steps     <= '0;
          sp        <= '0;
          cur_addr  <= '0;
        end
        FETCH: begin
          if (step_limit) out_error <= 1'b1;
          else            steps <= steps + STEP_W'(1);
        end
        DECODE: begin
          kids      <= mem_rdata.children;
          kid_count <= rd_count;
          idx       <= (mem_rdata.node_type == NODE_PARTITION) ? rd_count - 3'd1 : 3'd0;
          if (mem_rdata.node_type == NODE_LEAF && leaf_hit) begin
            out_found <= 1'b1;
            if (leaf_rule.weight < best_w) begin
              out_rule <= leaf_rule;
              best_w   <= leaf_rule.weight;
            end
          end
          if (mem_rdata.node_type == 2'd3) out_error <= 1'b1;
        end
        CUT_CHECK: begin
          if (child_hit) cur_addr <= ADDR_W'(kids[idx[1:0]]);
          else           idx <= idx + 3'd1;
        end
        PUSH: begin
          if (stack_full) out_error <= 1'b1;
          else begin
            sp  <= sp + SP_W'(1);
            idx <= idx - 3'd1;
          end
        end
        POP: if (sp != '0) begin
          cur_addr <= stack[top[IDX_W-1:0]];
          sp       <= top;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == PUSH && !stack_full) stack[sp[IDX_W-1:0]] <= ADDR_W'(kids[idx[1:0]]);
  end
endmodule

// File: tb/tb_tree_walk_classifier.sv
// tb/tb_tree_walk_classifier.sv - directed-vector bench for tree_walk_classifier
module tb_tree_walk_classifier;
  import tree_walk_classifier_pkg::*;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, mem_req, out_valid, out_ready, out_found, out_error;
  packet_s    in_packet;
  logic [7:0] in_tag, mem_addr, out_tag;
  node_s      mem_rdata;
  rule_s      out_rule;

  node_s      mem [256];
  logic [7:0] addr_log [$];
  int         assert_cnt = 0;
  int         fail_cnt = 0;
  int         lat;

  tree_walk_classifier #(.ADDR_W(8), .STACK_DEPTH(2), .MAX_STEPS(8), .TAG_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_packet(in_packet), .in_tag(in_tag), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_found(out_found), .out_rule(out_rule), .out_error(out_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req) mem_rdata <= mem[mem_addr];
  always @(negedge clk) if (mem_req) addr_log.push_back(mem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rule_s mk_rule(input logic [15:0] lo, input logic [15:0] hi,
                                    input logic [7:0] w, input logic [7:0] id);
    rule_s r;
    r.lo = lo; r.hi = hi; r.weight = w; r.id = id;
    return r;
  endfunction

  function automatic node_s mk_node(input logic [1:0] t, input logic [2:0] c,
                                    input logic [15:0] lo, input logic [15:0] hi);
    node_s n;
    n = '0;
    n.node_type = t; n.count = c; n.lo = lo; n.hi = hi;
    return n;
  endfunction

  function automatic logic [63:0] log_word();
    logic [63:0] w = '0;
    foreach (addr_log[i]) w = (w << 8) | 64'(addr_log[i]);
    return w;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  // Offer one packet, then wait (bounded) for out_valid; lat counts cycles with the accept cycle as 0.
  task automatic send(input logic [15:0] key, input logic [7:0] tag);
    addr_log.delete();
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_packet.key = key; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("in_ready_after_done", 64'(in_ready), 64'd1);
  endtask

  rule_s r_exp;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_packet = '0; in_tag = '0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mem_req",   64'(mem_req),   64'd0);
    check("rst_found",     64'(out_found), 64'd0);
    check("rst_error",     64'(out_error), 64'd0);
    check("rst_rule",      64'(out_rule),  64'd0);
    check("rst_tag",       64'(out_tag),   64'd0);

    // Leaf root, key 50 hits rules 1 (w7) and 2 (w3); rule 3 is past rule_count.
    mem[0] = mk_node(NODE_LEAF, 3'd3, 16'd0, 16'hffff);
    mem[0].rules[0] = mk_rule(16'd100, 16'd200, 8'd1, 8'd10);
    mem[0].rules[1] = mk_rule(16'd0,   16'd100, 8'd7, 8'd11);
    mem[0].rules[2] = mk_rule(16'd40,  16'd60,  8'd3, 8'd12);
    mem[0].rules[3] = mk_rule(16'd0,   16'hffff, 8'd0, 8'd13);
    send(16'd50, 8'h5a);
    check("leaf_latency", 64'(lat), 64'd4);
    check("leaf_found",   64'(out_found), 64'd1);
    check("leaf_error",   64'(out_error), 64'd0);
    check("leaf_rule",    64'(out_rule), 64'(mk_rule(16'd40, 16'd60, 8'd3, 8'd12)));
    check("leaf_tag",     64'(out_tag), 64'h5a);
    check("leaf_addrs",   log_word(), 64'h00);
    r_exp = mk_rule(16'd40, 16'd60, 8'd3, 8'd12);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid",    64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready),  64'd0);
      check("stall_rule",     64'(out_rule),  64'(r_exp));
      check("stall_tag",      64'(out_tag),   64'h5a);
    end
    drain();

    // Cut root: only child 12 covers key 50.
    clear_mem();
    mem[0] = mk_node(NODE_CUT, 3'd4, 16'd0, 16'hffff);
    mem[0].children[0] = 16'd10; mem[0].children[1] = 16'd11;
    mem[0].children[2] = 16'd12; mem[0].children[3] = 16'd13;
    mem[10] = mk_node(NODE_LEAF, 3'd0, 16'd200, 16'd300);
    mem[11] = mk_node(NODE_LEAF, 3'd0, 16'd300, 16'd400);
    mem[12] = mk_node(NODE_LEAF, 3'd1, 16'd0,   16'd99);
    mem[12].rules[0] = mk_rule(16'd0, 16'd99, 8'd5, 8'd20);
    mem[13] = mk_node(NODE_LEAF, 3'd0, 16'd400, 16'd500);
    send(16'd50, 8'h21);
    check("cut_addrs", log_word(), 64'h00_0a_0b_0c_0c);
    check("cut_found", 64'(out_found), 64'd1);
    check("cut_rule",  64'(out_rule), 64'(mk_rule(16'd0, 16'd99, 8'd5, 8'd20)));
    check("cut_error", 64'(out_error), 64'd0);
    drain();

    // Partition root with weights 9 then 4.
    clear_mem();
    mem[0] = mk_node(NODE_PARTITION, 3'd2, 16'd0, 16'hffff);
    mem[0].children[0] = 16'd20; mem[0].children[1] = 16'd21;
    mem[20] = mk_node(NODE_LEAF, 3'd1, 16'd0, 16'hffff);
    mem[20].rules[0] = mk_rule(16'd0, 16'd100, 8'd9, 8'd30);
    mem[21] = mk_node(NODE_LEAF, 3'd1, 16'd0, 16'hffff);
    mem[21].rules[0] = mk_rule(16'd0, 16'd100, 8'd4, 8'd31);
    send(16'd50, 8'h22);
    check("part_addrs", log_word(), 64'h00_14_15);
    check("part_rule",  64'(out_rule), 64'(mk_rule(16'd0, 16'd100, 8'd4, 8'd31)));
    check("part_error", 64'(out_error), 64'd0);
    drain();

    // Equal weights: the first-visited child keeps the result.
    mem[20].rules[0] = mk_rule(16'd0, 16'd100, 8'd4, 8'd32);
    mem[21].rules[0] = mk_rule(16'd0, 16'd100, 8'd4, 8'd33);
    send(16'd50, 8'h23);
    check("tie_rule", 64'(out_rule), 64'(mk_rule(16'd0, 16'd100, 8'd4, 8'd32)));
    drain();

    // Three children into a two-entry stack overflows before any child fetch.
    mem[0].count = 3'd3; mem[0].children[2] = 16'd22;
    send(16'd50, 8'h24);
    check("ovf_error", 64'(out_error), 64'd1);
    check("ovf_found", 64'(out_found), 64'd0);
    check("ovf_rule",  64'(out_rule),  64'd0);
    check("ovf_nreq",  64'(addr_log.size()), 64'd1);
    drain();

    // Self-referencing cut: 8 node fetches, each followed by one child probe.
    clear_mem();
    mem[0] = mk_node(NODE_CUT, 3'd1, 16'd0, 16'hffff);
    send(16'd50, 8'h25);
    check("steps_nreq",  64'(addr_log.size()), 64'd16);
    check("steps_error", 64'(out_error), 64'd1);
    check("steps_found", 64'(out_found), 64'd0);
    drain();

    // Unknown node type aborts at decode.
    mem[0] = mk_node(2'd3, 3'd0, 16'd0, 16'hffff);
    send(16'd50, 8'h26);
    check("badtype_error", 64'(out_error), 64'd1);
    check("badtype_nreq",  64'(addr_log.size()), 64'd1);
    drain();

    // Reset during a traversal.
    mem[0] = mk_node(NODE_CUT, 3'd1, 16'd0, 16'hffff);
    @(negedge clk);
    in_packet.key = 16'd1; in_tag = 8'h27; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_mem_req",   64'(mem_req),   64'd0);
    check("midrst_tag",       64'(out_tag),   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/tree_walk_classifier.md
TREE_WALK_CLASSIFIER -- requirements
Module: tree_walk_classifier

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set node address width; node memory depth is 2**ADDR_W; root node is at address 0.
REQ-002 Parameter STACK_DEPTH, default 16, SHALL set the number of entries in the pending-node stack used for PARTITION traversal.
REQ-003 Parameter MAX_STEPS, default 1024, SHALL bound the number of node visits per packet.
REQ-004 Parameter TAG_W, default 8, SHALL set the width of the opaque packet tag passed from input to result.
REQ-005 Port list, one per line, SHALL be:
  clk  in  1  clock
  reset  in  1  synchronous, active-high reset
  in_valid  in  1  packet offered
  in_ready  out  1  block can accept a packet
  in_packet  in  $bits(packet_s)  packet header
  in_tag  in  TAG_W  request tag
  mem_req  out  1  node read strobe
  mem_addr  out  ADDR_W  node address
  mem_rdata  in  $bits(node_s)  node word, valid exactly 1 cycle after mem_req
  out_valid  out  1  result held
  out_ready  in  1  consumer accepts result
  out_tag  out  TAG_W  tag of the classified packet
  out_found  out  1  at least one rule matched
  out_rule  out  $bits(rule_s)  lowest-weight matching rule
  out_error  out  1  traversal aborted (stack overflow, step limit, bad node type)

Function
REQ-006 Input handshake SHALL complete on a cycle with in_valid && in_ready; in_packet and in_tag SHALL be captured that cycle; in_ready SHALL be high only in IDLE.
REQ-007 FSM states SHALL be IDLE, FETCH, DECODE, CUT_FETCH, CUT_CHECK, PUSH, POP, DONE.
REQ-008 On accept: best weight <= all ones, out_found <= 0, out_error <= 0, step counter <= 0, stack emptied, current address <= 0, next state FETCH.
REQ-009 FETCH SHALL assert mem_req for one cycle with mem_addr = current address, increment the step counter, then go to DECODE, where mem_rdata is registered as the current node.
REQ-010 DECODE, LEAF node: all rules with index < rule_count SHALL be matched in one cycle via rule_match; the matching rule of lowest weight (ties: lowest index) SHALL replace the best rule only if its weight is strictly less than the best weight; out_found set on any match; then POP.
REQ-011 DECODE, CUT node: child index i <= 0, go to CUT_FETCH; CUT_FETCH SHALL issue mem_req for children[i]; CUT_CHECK SHALL test that child's range against the packet.
REQ-012 CUT_CHECK: on match, current address <= children[i], go to FETCH; on miss with i+1 < child_count, i++ and CUT_FETCH; on miss at last child (or child_count = 0), go to POP with no change to the best rule.
REQ-013 DECODE, PARTITION node: PUSH SHALL push children[0..child_count-1], one per cycle, in descending index order, so child 0 is visited first; then POP.
REQ-014 POP: stack non-empty -> pop top into current address, go to FETCH; stack empty -> DONE.
REQ-015 Abort conditions SHALL set out_error = 1 and go directly to DONE, preserving the best rule so far: a push with STACK_DEPTH entries already held; the step counter reaching MAX_STEPS at FETCH; an unknown node_type in DECODE.
REQ-016 DONE SHALL hold out_valid = 1 and keep out_tag, out_found, out_rule, out_error stable until out_valid && out_ready; then go to IDLE with in_ready = 1 on the next cycle.
REQ-017 out_rule SHALL be zero whenever out_found = 0.
REQ-018 mem_req SHALL be high only in FETCH and CUT_FETCH; mem_addr SHALL be don't-care otherwise.
REQ-019 Latency for a single LEAF root SHALL be: accept at cycle 0, FETCH 1, DECODE 2, POP 3, out_valid high at cycle 4.

Reset
REQ-020 reset SHALL take priority over all activity, including mid-traversal and DONE with out_ready low.
REQ-021 In the cycle after reset: state IDLE, in_ready = 1, out_valid = 0, mem_req = 0, out_found = 0, out_error = 0, out_rule = 0, out_tag = 0, stack empty, step counter 0.

Verification
REQ-022 Root LEAF with 3 rules, packet matching rules 1 (weight 7) and 2 (weight 3) -> out_valid at cycle 4, out_rule = rule 2, out_found = 1, out_error = 0.
REQ-023 Root CUT with 4 children, packet in child 2's range only, child 2 a LEAF matching weight 5 -> mem_addr sequence 0, c0, c1, c2, c2; out_rule weight 5.
REQ-024 Root PARTITION with 2 LEAF children matching weights 9 and 4 -> child 0 fetched before child 1; out_rule weight 4; equal weights 4/4 -> child 0's rule kept.
REQ-025 STACK_DEPTH = 2, PARTITION root with 3 children -> out_error = 1, out_found = 0, no further mem_req after the error.
REQ-026 Self-referencing CUT (child = 0, always matches), MAX_STEPS = 8 -> exactly 8 FETCH strobes, then out_error = 1.
REQ-027 out_ready held low 5 cycles in DONE -> outputs stable and in_ready = 0 throughout; reset asserted mid-traversal -> next cycle in_ready = 1, out_valid = 0.
